// File: rtl/slot_alloc_if.sv
// Allocation/free handshake bundle for slot_alloc. The requester side drives
// the i_* signals; the allocator drives the o_* status and grant signals.
interface slot_alloc_if #(
  parameter int N    = 16,
  parameter int ID_W = $clog2(N)
) ();
  logic            i_alloc_vld;
  logic            o_alloc_rdy;
  logic [ID_W-1:0] o_alloc_id;
  logic            i_free_vld;
  logic [ID_W-1:0] i_free_id;
  logic [N-1:0]    o_busy;
  logic [ID_W:0]   o_cnt;
  logic            o_full;
  logic            o_empty;
  logic            o_err;

  modport master (
    output i_alloc_vld, i_free_vld, i_free_id,
    input  o_alloc_rdy, o_alloc_id, o_busy, o_cnt, o_full, o_empty, o_err
  );

  modport slave (
    input  i_alloc_vld, i_free_vld, i_free_id,
    output o_alloc_rdy, o_alloc_id, o_busy, o_cnt, o_full, o_empty, o_err
  );
endinterface

// File: rtl/slot_alloc.sv
// Slot allocator: grants the first free slot (lowest or highest index) from a
// registered busy bitmap, accepts frees, tracks occupancy with a 3-state FSM.
module slot_alloc #(
  parameter int N        = 16,
  parameter int ID_W     = $clog2(N),
  parameter bit FROM_LSB = 1'b1
) (
  input logic         clk,
  input logic         rst,
  slot_alloc_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    busy, busy_nxt, grant_oh, free_mask;
  logic [ID_W:0]   cnt, cnt_nxt;
  logic [ID_W-1:0] grant_id;
  logic            err;
  logic            alloc_fire, free_in_range, free_ok;

  // Zero detect across the bitmap in search order; only the first zero survives.
  always_comb begin
    logic hit;
    hit      = 1'b0;
    grant_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (FROM_LSB) begin
        if (!busy[i] && !hit) begin
          grant_oh[i] = 1'b1;
          hit         = 1'b1;
        end
      end else begin
        if (!busy[N-1-i] && !hit) begin
          grant_oh[N-1-i] = 1'b1;
          hit             = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N; i++)
      if (grant_oh[i]) grant_id = grant_id | ID_W'(i);
  end

  assign alloc_fire    = bus.i_alloc_vld && (state != FULL);
  assign free_in_range = {1'b0, bus.i_free_id} < (ID_W+1)'(N);
  assign free_ok       = bus.i_free_vld && free_in_range && busy[bus.i_free_id];
  assign free_mask     = free_ok ? (N'(1) << bus.i_free_id) : '0;

  // The slot being freed is still busy pre-edge, so it can never be granted too.
  assign busy_nxt = (busy | (alloc_fire ? grant_oh : '0)) & ~free_mask;

  always_comb begin
    cnt_nxt = cnt;
    case ({alloc_fire, free_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (alloc_fire && !free_ok) state_nxt = PARTIAL;
      PARTIAL: begin
        if (cnt_nxt == (ID_W+1)'(N)) state_nxt = FULL;
        else if (cnt_nxt == '0)      state_nxt = EMPTY;
      end
      FULL:    if (free_ok) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
      if (bus.i_free_vld && !free_ok) err <= 1'b1;
    end
  end

  assign bus.o_alloc_rdy = (state != FULL);
  assign bus.o_alloc_id  = grant_id;
  assign bus.o_busy      = busy;
  assign bus.o_cnt       = cnt;
  assign bus.o_full      = (state == FULL);
  assign bus.o_empty     = (state == EMPTY);
  assign bus.o_err       = err;
endmodule
